// File: rtl/p09_brick_map.sv
// Brick map held as a ring of rows. Position 0 is the row at row_idx.
// Supports per-brick hits, whole-row writes, rotation and pattern reload.
module p09_brick_map #(
  parameter int NUM_ROWS = 15,
  parameter int NUM_COLS = 13,
  parameter int PATTERN  = 0,
  localparam int RW = $clog2(NUM_ROWS),
  localparam int HW = $clog2(NUM_COLS + 1),
  localparam int CW = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [NUM_COLS-1:0] line,
  output logic [RW-1:0]       row_idx,
  input  logic [NUM_COLS-1:0] new_line,
  input  logic                write_line,
  input  logic                next_line,
  input  logic                reset_state,
  input  logic                hit_valid,
  input  logic [HW-1:0]       hit_col,
  output logic                hit_ack,
  output logic                hit_brick,
  output logic [CW-1:0]       bricks_left,
  output logic                all_cleared
);

  function automatic logic [NUM_COLS-1:0] pattern_row(input int r);
    logic [NUM_COLS-1:0] row;
    int n;
    row = '0;
    if (PATTERN == 1) begin
      row = '1;
    end else begin
      n = (r > 1) ? r - 1 : 0;
      for (int c = 0; c < NUM_COLS; c++) row[c] = (c < n);
    end
    return row;
  endfunction

  function automatic int pattern_pop();
    int total;
    int n;
    total = 0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (PATTERN == 1) begin
        n = NUM_COLS;
      end else begin
        n = (r > 1) ? r - 1 : 0;
        if (n > NUM_COLS) n = NUM_COLS;
      end
      total = total + n;
    end
    return total;
  endfunction

  function automatic logic [CW:0] row_pop(input logic [NUM_COLS-1:0] v);
    logic [CW:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_COLS; i++) cnt = cnt + (CW+1)'(v[i]);
    return cnt;
  endfunction

  localparam int          POP   = pattern_pop();
  localparam logic [CW:0] POP_W = (CW+1)'(POP);
  localparam logic [CW:0] MAX_W = (CW+1)'(NUM_ROWS * NUM_COLS);

  logic [NUM_COLS-1:0] rows_q   [NUM_ROWS];
  logic [NUM_COLS-1:0] rows_d   [NUM_ROWS];
  logic [NUM_COLS-1:0] pat_rows [NUM_ROWS];
  logic [RW-1:0]       row_idx_q, row_idx_d;
  logic [CW-1:0]       bricks_left_q, bricks_left_d;
  logic                all_cleared_q;
  logic                hit_ack_q, hit_ack_d;
  logic                hit_brick_q, hit_brick_d;

  logic [NUM_COLS-1:0] cur_row;
  logic [NUM_COLS-1:0] hit_mask;
  logic                hit_present;
  logic [CW:0]         left_sum;
  logic [CW:0]         old_pop;

  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) pat_rows[r] = pattern_row(r);
  end

  // Out-of-range columns produce an empty mask, so they can never hit a brick.
  always_comb begin
    cur_row  = rows_q[row_idx_q];
    hit_mask = '0;
    for (int c = 0; c < NUM_COLS; c++) hit_mask[c] = (hit_col == HW'(c));
    hit_present = |(cur_row & hit_mask);
    old_pop     = row_pop(cur_row);
  end

  always_comb begin
    rows_d      = rows_q;
    row_idx_d   = row_idx_q;
    hit_ack_d   = 1'b0;
    hit_brick_d = hit_brick_q;
    left_sum    = {1'b0, bricks_left_q};

    if (reset_state) begin
      rows_d    = pat_rows;
      row_idx_d = '0;
      left_sum  = POP_W;
    end else if (write_line) begin
      rows_d[row_idx_q] = new_line;
      left_sum = left_sum + row_pop(new_line);
      if (left_sum >= old_pop) left_sum = left_sum - old_pop;
      else                     left_sum = '0;
      if (left_sum > MAX_W) left_sum = MAX_W;
    end else begin
      // The hit lands on the current row before any rotation this cycle.
      if (hit_valid) begin
        hit_ack_d   = 1'b1;
        hit_brick_d = hit_present;
        if (hit_present) begin
          rows_d[row_idx_q] = cur_row & ~hit_mask;
          if (left_sum != '0) left_sum = left_sum - (CW+1)'(1);
        end
      end
      if (next_line) begin
        row_idx_d = (row_idx_q == RW'(NUM_ROWS - 1)) ? '0 : row_idx_q + RW'(1);
      end
    end

    bricks_left_d = left_sum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q        <= pat_rows;
      row_idx_q     <= '0;
      bricks_left_q <= POP_W[CW-1:0];
      all_cleared_q <= (POP == 0);
      hit_ack_q     <= 1'b0;
      hit_brick_q   <= 1'b0;
    end else begin
      rows_q        <= rows_d;
      row_idx_q     <= row_idx_d;
      bricks_left_q <= bricks_left_d;
      all_cleared_q <= (bricks_left_d == '0);
      hit_ack_q     <= hit_ack_d;
      hit_brick_q   <= hit_brick_d;
    end
  end

  assign line        = rows_q[row_idx_q];
  assign row_idx     = row_idx_q;
  assign bricks_left = bricks_left_q;
  assign all_cleared = all_cleared_q;
  assign hit_ack     = hit_ack_q;
  assign hit_brick   = hit_brick_q;

endmodule

// File: tb/tb_p09_brick_map.sv
// Testbench for p09_brick_map: directed vector table, corner sequences,
// then random commands checked against a queue-based ring model.
module tb_p09_brick_map;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_RST  = 5'b10000;
  localparam logic [4:0] C_RS   = 5'b01000;
  localparam logic [4:0] C_WL   = 5'b00100;
  localparam logic [4:0] C_NL   = 5'b00010;
  localparam logic [4:0] C_HV   = 5'b00001;

  logic        clk;
  logic        rst;
  logic [12:0] line;
  logic [3:0]  row_idx;
  logic [12:0] new_line;
  logic        write_line;
  logic        next_line;
  logic        reset_state;
  logic        hit_valid;
  logic [3:0]  hit_col;
  logic        hit_ack;
  logic        hit_brick;
  logic [7:0]  bricks_left;
  logic        all_cleared;

  int n_checks;
  int n_pass;

  typedef struct {
    logic [4:0]  cmd;
    logic [3:0]  hc;
    logic [12:0] nd;
    logic [12:0] e_line;
    logic [3:0]  e_idx;
    logic [7:0]  e_left;
    logic [2:0]  e_flags;
  } vec_t;

  vec_t vecs[15];

  logic [12:0] m_rows[$];
  int          m_idx;
  logic        m_ack;
  logic        m_brick;

  p09_brick_map dut (
    .clk         (clk),
    .rst         (rst),
    .line        (line),
    .row_idx     (row_idx),
    .new_line    (new_line),
    .write_line  (write_line),
    .next_line   (next_line),
    .reset_state (reset_state),
    .hit_valid   (hit_valid),
    .hit_col     (hit_col),
    .hit_ack     (hit_ack),
    .hit_brick   (hit_brick),
    .bricks_left (bricks_left),
    .all_cleared (all_cleared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [4:0] cmd, input logic [3:0] hc, input logic [12:0] nd);
    {rst, reset_state, write_line, next_line, hit_valid} = cmd;
    hit_col  = hc;
    new_line = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [12:0] e_line, input logic [3:0] e_idx,
                             input logic [7:0] e_left, input logic [2:0] e_flags);
    n_checks++;
    if ({line, row_idx, bricks_left, all_cleared, hit_ack, hit_brick} === {e_line, e_idx, e_left, e_flags}) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got line=%h idx=%0d left=%0d clr/ack/brick=%b%b%b, expected line=%h idx=%0d left=%0d clr/ack/brick=%b",
               name, line, row_idx, bricks_left, all_cleared, hit_ack, hit_brick, e_line, e_idx, e_left, e_flags);
    end
  endtask

  function automatic logic [12:0] patRow(input int r);
    int n;
    n = (r > 1) ? r - 1 : 0;
    if (n > 13) n = 13;
    return 13'((1 << n) - 1);
  endfunction

  task automatic modelStep(input logic [4:0] cmd, input logic [3:0] hc, input logic [12:0] nd);
    logic [12:0] tmp;
    int col;
    if (cmd[4] || cmd[3]) begin
      m_rows.delete();
      for (int r = 0; r < 15; r++) m_rows.push_back(patRow(r));
      m_idx = 0;
      m_ack = 1'b0;
      if (cmd[4]) m_brick = 1'b0;
    end else if (cmd[2]) begin
      m_rows[0] = nd;
      m_ack = 1'b0;
    end else begin
      m_ack = cmd[0];
      if (cmd[0]) begin
        col = int'(hc);
        tmp = m_rows[0];
        m_brick = 1'b0;
        if (col < 13) begin
          if (tmp[col]) begin
            tmp[col] = 1'b0;
            m_brick = 1'b1;
          end
        end
        m_rows[0] = tmp;
      end
      if (cmd[1]) begin
        m_rows.push_back(m_rows.pop_front());
        m_idx = (m_idx + 1) % 15;
      end
    end
  endtask

  function automatic int modelCount();
    int total;
    total = 0;
    foreach (m_rows[i]) total += $countones(m_rows[i]);
    return total;
  endfunction

  initial begin
    int total;
    logic [4:0]  cmd;
    logic [3:0]  hc;
    logic [12:0] nd;

    n_checks = 0;
    n_pass   = 0;
    {rst, reset_state, write_line, next_line, hit_valid} = 5'b0;
    hit_col  = 4'd0;
    new_line = 13'd0;
    @(negedge clk);

    // Directed table: expected state after each edge, flags = {all_cleared, hit_ack, hit_brick}.
    vecs[0]  = '{C_RST,             4'd0,  13'd0,      13'd0,      4'd0, 8'd91,  3'b000};
    vecs[1]  = '{C_NL,              4'd0,  13'd0,      13'd0,      4'd1, 8'd91,  3'b000};
    vecs[2]  = '{C_NL,              4'd0,  13'd0,      13'd1,      4'd2, 8'd91,  3'b000};
    vecs[3]  = '{C_HV,              4'd0,  13'd0,      13'd0,      4'd2, 8'd90,  3'b011};
    vecs[4]  = '{C_HV,              4'd0,  13'd0,      13'd0,      4'd2, 8'd90,  3'b010};
    vecs[5]  = '{C_HV,              4'd13, 13'd0,      13'd0,      4'd2, 8'd90,  3'b010};
    vecs[6]  = '{C_NL,              4'd0,  13'd0,      13'd3,      4'd3, 8'd90,  3'b000};
    vecs[7]  = '{C_HV,              4'd1,  13'd0,      13'd1,      4'd3, 8'd89,  3'b011};
    vecs[8]  = '{C_NONE,            4'd0,  13'd0,      13'd1,      4'd3, 8'd89,  3'b001};
    vecs[9]  = '{C_RS | C_WL | C_HV, 4'd0, 13'h1FFF,   13'd0,      4'd0, 8'd91,  3'b001};
    vecs[10] = '{C_WL,              4'd0,  13'h1FFF,   13'h1FFF,   4'd0, 8'd104, 3'b001};
    vecs[11] = '{C_WL | C_NL,       4'd0,  13'd0,      13'd0,      4'd0, 8'd91,  3'b001};
    vecs[12] = '{C_RST | C_HV,      4'd0,  13'd0,      13'd0,      4'd0, 8'd91,  3'b000};
    vecs[13] = '{C_HV,              4'd12, 13'd0,      13'd0,      4'd0, 8'd91,  3'b010};
    vecs[14] = '{C_RST,             4'd0,  13'd0,      13'd0,      4'd0, 8'd91,  3'b000};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].cmd, vecs[i].hc, vecs[i].nd);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_line, vecs[i].e_idx, vecs[i].e_left, vecs[i].e_flags);
    end

    // Hit combined with rotation on the last row, then walk back to it.
    applyStimulus(C_RS, 4'd0, 13'd0);
    for (int i = 0; i < 14; i++) applyStimulus(C_NL, 4'd0, 13'd0);
    checkOutput("at_row14", 13'h1FFF, 4'd14, 8'd91, 3'b000);
    applyStimulus(C_NL | C_HV, 4'd12, 13'd0);
    checkOutput("hit_rotate", 13'd0, 4'd0, 8'd90, 3'b011);
    for (int i = 0; i < 14; i++) applyStimulus(C_NL, 4'd0, 13'd0);
    checkOutput("rotated_row", 13'h0FFF, 4'd14, 8'd90, 3'b001);

    // Clear every row, probe underflow, then reload.
    applyStimulus(C_RS, 4'd0, 13'd0);
    for (int r = 0; r < 15; r++) begin
      applyStimulus(C_WL, 4'd0, 13'd0);
      applyStimulus(C_NL, 4'd0, 13'd0);
    end
    checkOutput("all_clear", 13'd0, 4'd0, 8'd0, 3'b101);
    applyStimulus(C_HV, 4'd0, 13'd0);
    checkOutput("empty_hit", 13'd0, 4'd0, 8'd0, 3'b110);
    applyStimulus(C_RS, 4'd0, 13'd0);
    checkOutput("reload", 13'd0, 4'd0, 8'd91, 3'b000);

    // Random commands against the queue model.
    applyStimulus(C_RST, 4'd0, 13'd0);
    modelStep(C_RST, 4'd0, 13'd0);
    for (int i = 0; i < 600; i++) begin
      cmd    = C_NONE;
      cmd[4] = ($urandom_range(0, 99) < 2);
      cmd[3] = ($urandom_range(0, 99) < 3);
      cmd[2] = ($urandom_range(0, 99) < 12);
      cmd[1] = ($urandom_range(0, 99) < 45);
      cmd[0] = ($urandom_range(0, 99) < 55);
      hc     = 4'($urandom_range(0, 15));
      nd     = ($urandom_range(0, 2) == 0) ? 13'd0 : 13'($urandom);
      applyStimulus(cmd, hc, nd);
      modelStep(cmd, hc, nd);
      total = modelCount();
      checkOutput($sformatf("rand%0d", i), m_rows[0], 4'(m_idx), 8'(total),
                  {(total == 0), m_ack, m_brick});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
